uart_rx_frame_controller: RTL and testbench
===========================================

Name: uart_rx_frame_controller

Overview:
- Sequences the UART receive path: synchronises the raw RX line, detects the start bit, and generates its own oversampling tick, re-aligned to each start edge.
- Samples each bit at mid-period, assembles 8N1 frames LSB-first and checks the stop bit.
- Hands completed bytes to downstream logic over a valid/ready handshake, with frame-error and overrun reporting.
- Replaces the free-running baud tick plus SIPO sampling scheme as the block that drives byte capture.

Parameters:
- TICK_DIV, 27: clk_25mhz cycles per oversample tick (25 MHz / (115200 × 8) ≈ 27).
- OVERSAMPLE, 8: ticks per bit period. Must be even and ≥ 4.
- DATA_BITS, 8: data bits per frame.

Ports:
- clk_25mhz  input  1  system clock, 25 MHz.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- rx_data  input  1  raw serial line, asynchronous, idle high.
- data_out  output  DATA_BITS  received byte; valid while data_valid=1.
- data_valid  output  1  byte available.
- data_ready  input  1  consumer accepts the byte.
- frame_error  output  1  1-cycle pulse: stop bit sampled 0.
- overrun  output  1  1-cycle pulse: good frame dropped because the holding register was full.
- busy  output  1  FSM not in IDLE.
- sample_tick  output  1  1-cycle pulse on every mid-bit sample (start, data and stop bits).

Behaviour:
- Reset (reset=0, asynchronous): FSM→IDLE; data_out=0, data_valid=0, frame_error=0, overrun=0, busy=0, sample_tick=0; tick and bit counters=0; synchroniser flops=1.
- Synchroniser: rx_data passes through 2 flops to give rx_s. All decisions use rx_s only.
- Tick counter:
  - Counts 0..TICK_DIV-1; tick=1 on the cycle the counter equals TICK_DIV-1, then wraps to 0.
  - Held at 0 in IDLE and BREAK; cleared on the start-detect cycle.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: the first cycle with rx_s=0 moves to START and clears the oversample count.
- START:
  - On the OVERSAMPLE/2-th tick, sample rx_s and pulse sample_tick.
  - rx_s=0 → DATA, with bit index=0 and oversample count=0.
  - rx_s=1 → IDLE (glitch rejected, no flags raised).
- DATA:
  - Every OVERSAMPLE ticks, sample rx_s into the shift register, filling from the MSB and shifting right (LSB-first on the wire). Pulse sample_tick.
  - After DATA_BITS samples → STOP.
- STOP: after OVERSAMPLE ticks, sample rx_s and pulse sample_tick.
  - rx_s=1: good frame. If data_valid=0, or data_valid=1 and data_ready=1 on this cycle, load data_out and set data_valid=1 on the next cycle. Otherwise hold the old byte, discard the new one, and pulse overrun. Then → IDLE.
  - rx_s=0: pulse frame_error, discard the byte, leave data_valid/data_out untouched, → BREAK.
- BREAK: wait for rx_s=1, then → IDLE. No start detection while in BREAK.
- Handshake:
  - data_valid clears the cycle after data_valid & data_ready.
  - Simultaneous accept and new load: data_valid stays 1 and data_out takes the new byte.
  - data_out is stable while data_valid=1 and not accepted.
- Latency: data_valid rises 1 clk after the stop-bit sample tick. The stop sample falls about (1.5 + DATA_BITS) × OVERSAMPLE × TICK_DIV clocks after the start-detect cycle (≈2052 clocks with defaults). Start detection lags rx_data by 2–3 clocks.
- Mid-frame reset: immediate return to reset state. The partial frame is lost, and the next start edge after release is received normally.
- busy = (state != IDLE).

Test Plan:
- Send 0xA5, 8N1, bit period 216 clocks, data_ready=1 → data_out=0xA5 and data_valid=1 for exactly 1 cycle, about 2052–2056 clocks after the falling edge. Exactly 10 sample_tick pulses; frame_error=0, overrun=0.
- Low glitch of 50 clocks on an idle line → no data_valid, no frame_error, busy=1 for about 108 clocks then 0. A following frame 0x3C is received correctly.
- Frame 0x3C with stop bit=0, then line held low 500 clocks, then high → one frame_error pulse, data_valid stays 0, busy stays 1 until rx_s=1. The next frame 0x81 is received as 0x81.
- Frames 0x11 then 0x22 back-to-back with data_ready=0 → data_out=0x11, data_valid=1, one overrun pulse at the 0x22 stop sample. Then data_ready=1 for 1 cycle → data_valid=0 next cycle.
- data_valid=1 holding 0x11, and data_ready=1 on the exact cycle 0x22's stop sample occurs → no overrun, data_valid stays 1, data_out=0x22.
- Assert reset=0 for 5 clocks during data bit 4 of 0xFF → all outputs 0 within the reset cycles, no data_valid. A following frame 0x5A is received as 0x5A.

Source files
------------

// File: rtl/uart_rx_frame_controller_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_frame_controller_if : received-byte handoff (valid/ready + flags)
// Rev 1.0
// ----------------------------------------------------------------------------
interface uart_rx_frame_controller_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 frame_error;
  logic                 overrun;

  modport master (
    output data_out,
    output data_valid,
    output frame_error,
    output overrun,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  frame_error,
    input  overrun,
    output data_ready
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_frame_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_frame_controller : 8N1 UART receiver, oversample tick re-aligned to
// every start edge, mid-bit sampling and valid/ready byte handoff. Rev 1.0
// ----------------------------------------------------------------------------
module uart_rx_frame_controller #(
  parameter int TICK_DIV   = 27,
  parameter int OVERSAMPLE = 8,
  parameter int DATA_BITS  = 8
) (
  input  logic                       clk_25mhz,
  input  logic                       reset,
  input  logic                       rx_data,
  uart_rx_frame_controller_if.master rx_bus,
  output logic                       busy,
  output logic                       sample_tick
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int OS_W   = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TICK_W-1:0] c_tick_last    = TICK_W'(TICK_DIV - 1);
  localparam logic [OS_W-1:0]   c_os_last      = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]   c_os_half_last = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0]  c_bit_last     = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t               state_q;
  logic                 sync1_q;
  logic                 rx_s_q;
  logic [TICK_W-1:0]    tick_cnt_q;
  logic [TICK_W-1:0]    tick_cnt_d;
  logic [OS_W-1:0]      os_cnt_q;
  logic [BIT_W-1:0]     bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 ovr_q;

  logic                 w_counting;
  logic                 w_tick;
  logic                 w_sample;
  logic [DATA_BITS-1:0] w_shift_next;

  // The tick only runs while a frame is in flight, so it re-phases to each start edge.
  assign w_counting = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
  assign w_tick     = w_counting && (tick_cnt_q == c_tick_last);
  assign w_sample   = w_tick && ((state_q == S_START) ? (os_cnt_q == c_os_half_last)
                                                      : (os_cnt_q == c_os_last));

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (!w_counting || (tick_cnt_q == c_tick_last)) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end
  end

  generate
    if (DATA_BITS > 1) begin : g_shift_multi
      assign w_shift_next = {rx_s_q, shift_q[DATA_BITS-1:1]};
    end else begin : g_shift_single
      assign w_shift_next = rx_s_q;
    end
  endgenerate

  always_ff @(posedge clk_25mhz or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      tick_cnt_q <= '0;
    end else begin
      sync1_q    <= rx_data;
      rx_s_q     <= sync1_q;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  always_ff @(posedge clk_25mhz or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      os_cnt_q  <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      if (valid_q && rx_bus.data_ready) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_q  <= S_START;
            os_cnt_q <= '0;
          end
        end

        S_START: begin
          if (w_sample) begin
            os_cnt_q  <= '0;
            bit_idx_q <= '0;
            state_q   <= rx_s_q ? S_IDLE : S_DATA;
          end else if (w_tick) begin
            os_cnt_q <= os_cnt_q + 1'b1;
          end
        end

        S_DATA: begin
          if (w_sample) begin
            os_cnt_q <= '0;
            shift_q  <= w_shift_next;
            if (bit_idx_q == c_bit_last) begin
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else if (w_tick) begin
            os_cnt_q <= os_cnt_q + 1'b1;
          end
        end

        S_STOP: begin
          if (w_sample) begin
            os_cnt_q <= '0;
            if (rx_s_q) begin
              state_q <= S_IDLE;
              // A same-cycle accept frees the holding register for the new byte.
              if (!valid_q || rx_bus.data_ready) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                ovr_q <= 1'b1;
              end
            end else begin
              ferr_q  <= 1'b1;
              state_q <= S_BREAK;
            end
          end else if (w_tick) begin
            os_cnt_q <= os_cnt_q + 1'b1;
          end
        end

        S_BREAK: begin
          if (rx_s_q) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rx_bus.data_out    = data_q;
  assign rx_bus.data_valid  = valid_q;
  assign rx_bus.frame_error = ferr_q;
  assign rx_bus.overrun     = ovr_q;
  assign busy               = (state_q != S_IDLE);
  assign sample_tick        = w_sample;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_rx_frame_controller : directed and random 8N1 frames against a
// line-level receiver model. Rev 1.0
// ----------------------------------------------------------------------------
module tb_uart_rx_frame_controller;

  localparam int TICK_DIV   = 27;
  localparam int OVERSAMPLE = 8;
  localparam int DATA_BITS  = 8;
  localparam int BIT_CLKS   = TICK_DIV * OVERSAMPLE;           // 216
  localparam int FIRST_OFF  = (OVERSAMPLE / 2) * TICK_DIV;     // rx_s low -> start sample
  localparam int FRAME_CLKS = 10 * BIT_CLKS;
  localparam int STOP_OFF   = 2 + FIRST_OFF + 9 * BIT_CLKS;    // line edge -> stop sample
  localparam int MAX_FAIL   = 40;

  logic clk_25mhz = 1'b0;
  logic reset;
  logic rx_data;
  logic data_ready;
  logic busy;
  logic sample_tick;

  always #5 clk_25mhz = ~clk_25mhz;

  uart_rx_frame_controller_if #(.DATA_BITS(DATA_BITS)) bus ();
  assign bus.data_ready = data_ready;

  uart_rx_frame_controller #(
    .TICK_DIV  (TICK_DIV),
    .OVERSAMPLE(OVERSAMPLE),
    .DATA_BITS (DATA_BITS)
  ) dut (
    .clk_25mhz  (clk_25mhz),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_bus     (bus),
    .busy       (busy),
    .sample_tick(sample_tick)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Receiver model: line history through two stages, frame timed from the detect cycle.
  logic       s1 = 1'b1, s2 = 1'b1, rx_last = 1'b1;
  int         mode = 0;   // 0 idle, 1 in frame, 2 waiting for line high
  int         t0 = 0;
  logic       m_valid = 1'b0, m_fe = 1'b0, m_ov = 1'b0;
  logic [7:0] m_data = 8'h00, m_byte = 8'h00;

  int         o_tick = 0, o_valid = 0, o_fe = 0, o_ov = 0, o_busy = 0, o_rst_bad = 0;
  int         rise_cyc = 0;
  logic [7:0] rise_data = 8'h00;
  logic       prev_v = 1'b0;
  int         b_tick, b_valid, b_fe, b_ov, b_busy, b_rst_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_cycle();
    logic        rxs, e_tick, old_valid, nfe, nov;
    logic [12:0] exp_v, act_v;
    int          j;
    if (!reset) begin
      s1 = 1'b1; s2 = 1'b1; mode = 0;
      m_valid = 1'b0; m_data = 8'h00; m_fe = 1'b0; m_ov = 1'b0;
    end else begin
      s2 = s1;
      s1 = rx_last;
    end
    rx_last = rx_data;
    rxs     = s2;
    e_tick  = (mode == 1) && (cyc >= t0 + FIRST_OFF) && (((cyc - t0 - FIRST_OFF) % BIT_CLKS) == 0);
    exp_v   = {mode != 0, e_tick, m_valid, m_fe, m_ov, m_data};
    act_v   = {busy, sample_tick, bus.data_valid, bus.frame_error, bus.overrun, bus.data_out};
    check("cycle {busy,tick,valid,ferr,ovr,data}", 32'(act_v), 32'(exp_v));

    o_tick  += int'(sample_tick);
    o_valid += int'(bus.data_valid);
    o_fe    += int'(bus.frame_error);
    o_ov    += int'(bus.overrun);
    o_busy  += int'(busy);
    if (!reset && (act_v != 13'd0)) o_rst_bad++;
    if (bus.data_valid && !prev_v) begin
      rise_cyc  = cyc;
      rise_data = bus.data_out;
    end
    prev_v = bus.data_valid;

    if (reset) begin
      nfe = 1'b0;
      nov = 1'b0;
      old_valid = m_valid;
      if (m_valid && data_ready) m_valid = 1'b0;
      case (mode)
        0: if (!rxs) begin mode = 1; t0 = cyc; end
        1: if (e_tick) begin
             j = (cyc - t0 - FIRST_OFF) / BIT_CLKS;
             if (j == 0) begin
               if (rxs) mode = 0;
             end else if (j <= DATA_BITS) begin
               m_byte[j-1] = rxs;
             end else if (rxs) begin
               mode = 0;
               if (!old_valid || data_ready) begin
                 m_valid = 1'b1;
                 m_data  = m_byte;
               end else begin
                 nov = 1'b1;
               end
             end else begin
               nfe  = 1'b1;
               mode = 2;
             end
           end
        default: if (rxs) mode = 0;
      endcase
      m_fe = nfe;
      m_ov = nov;
    end
  endtask

  task automatic step();
    @(negedge clk_25mhz);
    model_cycle();
    @(posedge clk_25mhz);
    #1;
    cyc++;
  endtask

  function automatic logic ready_val(input int rmode, input int n, input int pulse_off);
    case (rmode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return ($urandom_range(0, 3) == 0);
      default: return (n == pulse_off);
    endcase
  endfunction

  task automatic idle(input int n, input int rmode);
    for (int i = 0; i < n; i++) begin
      rx_data    = 1'b1;
      data_ready = ready_val(rmode, i, -1);
      step();
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_b, input int extra_low,
                            input int rmode, input int pulse_off, input int rst_at, input int rst_len);
    logic [9:0] fr;
    fr = {stop_b, b, 1'b0};
    for (int n = 0; n < FRAME_CLKS + extra_low; n++) begin
      rx_data    = (n < FRAME_CLKS) ? fr[n / BIT_CLKS] : 1'b0;
      data_ready = ready_val(rmode, n, pulse_off);
      reset      = !((rst_at >= 0) && (n >= rst_at) && (n < rst_at + rst_len));
      step();
    end
    reset = 1'b1;
  endtask

  task automatic snap();
    b_tick = o_tick; b_valid = o_valid; b_fe = o_fe; b_ov = o_ov;
    b_busy = o_busy; b_rst_bad = o_rst_bad;
  endtask

  task automatic t_basic();
    int e;
    snap();
    e = cyc;
    send_frame(8'hA5, 1'b1, 0, 1, -1, -1, 0);
    idle(100, 1);
    check("a5_sample_ticks", 32'(o_tick - b_tick), 32'd10);
    check("a5_valid_cycles", 32'(o_valid - b_valid), 32'd1);
    check("a5_data", 32'(rise_data), 32'h0000_00A5);
    check("a5_latency", 32'(rise_cyc - e), 32'd2055);
    check("a5_frame_error", 32'(o_fe - b_fe), 32'd0);
    check("a5_overrun", 32'(o_ov - b_ov), 32'd0);
  endtask

  task automatic t_glitch();
    snap();
    for (int i = 0; i < 50; i++) begin
      rx_data = 1'b0;
      step();
    end
    idle(300, 1);
    check("glitch_busy_cycles", 32'(o_busy - b_busy), 32'd108);
    check("glitch_sample_ticks", 32'(o_tick - b_tick), 32'd1);
    check("glitch_valid", 32'(o_valid - b_valid), 32'd0);
    check("glitch_frame_error", 32'(o_fe - b_fe), 32'd0);
    snap();
    send_frame(8'h3C, 1'b1, 0, 1, -1, -1, 0);
    idle(100, 1);
    check("after_glitch_data", 32'(rise_data), 32'h0000_003C);
    check("after_glitch_valid_cycles", 32'(o_valid - b_valid), 32'd1);
  endtask

  task automatic t_break();
    snap();
    send_frame(8'h3C, 1'b0, 500, 1, -1, -1, 0);
    check("break_busy_while_low", 32'(busy), 32'd1);
    idle(50, 1);
    check("break_busy_after_high", 32'(busy), 32'd0);
    check("break_frame_errors", 32'(o_fe - b_fe), 32'd1);
    check("break_valid", 32'(o_valid - b_valid), 32'd0);
    snap();
    send_frame(8'h81, 1'b1, 0, 1, -1, -1, 0);
    idle(100, 1);
    check("after_break_data", 32'(rise_data), 32'h0000_0081);
  endtask

  task automatic t_overrun();
    snap();
    send_frame(8'h11, 1'b1, 0, 0, -1, -1, 0);
    send_frame(8'h22, 1'b1, 0, 0, -1, -1, 0);
    idle(100, 0);
    check("ovr_pulses", 32'(o_ov - b_ov), 32'd1);
    check("ovr_held_data", 32'(bus.data_out), 32'h0000_0011);
    check("ovr_held_valid", 32'(bus.data_valid), 32'd1);
    rx_data    = 1'b1;
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;
    check("ovr_valid_after_accept", 32'(bus.data_valid), 32'd0);
    idle(50, 0);
  endtask

  task automatic t_accept_and_load();
    send_frame(8'h11, 1'b1, 0, 0, -1, -1, 0);
    snap();
    send_frame(8'h22, 1'b1, 0, 3, STOP_OFF, -1, 0);
    idle(50, 0);
    check("swap_overrun", 32'(o_ov - b_ov), 32'd0);
    check("swap_valid", 32'(bus.data_valid), 32'd1);
    check("swap_data", 32'(bus.data_out), 32'h0000_0022);
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;
    idle(20, 0);
  endtask

  task automatic t_reset_mid_frame();
    snap();
    send_frame(8'hFF, 1'b1, 0, 1, -1, 5 * BIT_CLKS + 100, 5);
    idle(100, 1);
    check("rst_outputs_nonzero", 32'(o_rst_bad - b_rst_bad), 32'd0);
    check("rst_valid", 32'(o_valid - b_valid), 32'd0);
    snap();
    send_frame(8'h5A, 1'b1, 0, 1, -1, -1, 0);
    idle(100, 1);
    check("after_rst_data", 32'(rise_data), 32'h0000_005A);
  endtask

  task automatic t_random();
    logic [7:0] b;
    logic       err;
    for (int k = 0; k < 12; k++) begin
      if (n_fail > MAX_FAIL) break;
      if ($urandom_range(0, 5) == 0) begin
        for (int i = 0; i < int'($urandom_range(5, 90)); i++) begin
          rx_data = 1'b0;
          step();
        end
        idle(200, 2);
      end
      b   = 8'($urandom);
      err = ($urandom_range(0, 4) == 0);
      send_frame(b, !err, err ? int'($urandom_range(0, 300)) : 0, 2, -1, -1, 0);
      idle(int'($urandom_range(0, 300)), 2);
    end
  endtask

  initial begin
    reset      = 1'b0;
    rx_data    = 1'b1;
    data_ready = 1'b0;
    @(posedge clk_25mhz);
    #1;
    step();
    step();
    check("reset_outputs", 32'({busy, sample_tick, bus.data_valid, bus.frame_error,
                                bus.overrun, bus.data_out}), 32'd0);
    reset = 1'b1;
    idle(20, 1);

    t_basic();
    if (n_fail <= MAX_FAIL) t_glitch();
    if (n_fail <= MAX_FAIL) t_break();
    if (n_fail <= MAX_FAIL) t_overrun();
    if (n_fail <= MAX_FAIL) t_accept_and_load();
    if (n_fail <= MAX_FAIL) t_reset_mid_frame();
    if (n_fail <= MAX_FAIL) t_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
